hht_mem_responder: RTL and testbench
====================================

Name: hht_mem_responder

Overview:
- Memory-side responder for the HHT `control` block's two read ports.
  - Port 1 (addr1/dataIn1) serves the column-index stream.
  - Port 2 (addr2/dataIn2) serves the vector-value stream.
- Replaces behavioural case-statement memory with a synthesizable, CPU-loadable store that has fixed, pipelined read latency.
- Sits between `control` and the CPU write path; the CPU loads contents, the HHT reads them.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, address width of both read ports and the write port
- DEPTH, 512, number of words stored, addresses 0..DEPTH-1
- RD_LAT, 2, read latency in cycles (legal range 1..4)
- DEFAULT_DATA, 99999, value returned for unwritten or out-of-range addresses

Ports:
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  asynchronous active-low reset
- mem_init  in  1  pulse: clear the whole store to DEFAULT_DATA
- WR  in  1  CPU write strobe
- wr_addr  in  ADDR_W  CPU write address
- wr_data  in  DATA_W  CPU write data
- req1  in  1  port-1 read request
- addr1  in  ADDR_W  port-1 read address
- dataIn1  out  DATA_W  port-1 read data
- valid1  out  1  port-1 data valid
- req2  in  1  port-2 read request
- addr2  in  ADDR_W  port-2 read address
- dataIn2  out  DATA_W  port-2 read data
- valid2  out  1  port-2 data valid
- busy  out  1  high while the init sweep runs

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to INIT and the sweep counter to 0.
  - valid1, valid2 and all pipeline valid bits are 0.
  - dataIn1 and dataIn2 are DEFAULT_DATA.
  - busy is 1.
  - The store is not touched by reset itself; the INIT sweep clears it.
- State machine:
  - INIT writes DEFAULT_DATA to one word per cycle, addresses 0..DEPTH-1, so it lasts DEPTH cycles.
  - After the last word it moves to READY and busy falls on the next edge.
  - From READY, mem_init=1 returns to INIT with the counter at 0.
  - mem_init during INIT restarts the sweep at 0.
- Reads (READY only):
  - A request (reqN=1) sampled at edge k produces validN=1 and dataInN at edge k+RD_LAT.
  - Each port is fully pipelined and accepts one request per cycle.
  - The two ports are independent, and the same address on both ports is legal.
  - validN is high for exactly one cycle per request.
  - dataInN holds its last value when validN=0.
- Out-of-range: address >= DEPTH returns DEFAULT_DATA with valid asserted; no error flag is raised.
- Writes:
  - WR=1 in READY with wr_addr < DEPTH updates the word at the edge.
  - Out-of-range writes are dropped.
  - WR during INIT is dropped.
  - WR and mem_init in the same cycle: mem_init wins and the write is dropped.
- Read/write collision:
  - A read sampled in the same cycle as a write to the same address returns the old data (read-before-write).
  - A read in the next cycle returns the new data.
- Requests during INIT are dropped: no valid pulse is ever issued for them.
  - In-flight requests already in the pipeline when mem_init is accepted are still delivered, carrying their pre-init data.
- Reset mid-operation clears all pipeline valids immediately, so no stale valid is produced after Rst rises.

Optional Feature:
- Macro: HHT_MEM_STATS_EN.
- When defined, the block adds:
  - Outputs rd_cnt1, rd_cnt2 and oor_cnt, each 32 bits.
  - rd_cnt1 and rd_cnt2 count accepted requests per port.
  - oor_cnt counts accepted out-of-range reads on both ports; if both ports hit out-of-range in the same cycle, it increments by 2.
  - All counters saturate at all-ones, clear on reset, and clear on mem_init.
- When undefined, these ports and counters do not exist, and functional behaviour is otherwise identical.

Decomposition:
- Package hht_mem_pkg holds:
  - the state enum {INIT, READY};
  - the constant HHT_MEM_DEFAULT = 99999;
  - the latency limits RD_LAT_MIN = 1 and RD_LAT_MAX = 4.
- Sub-module hht_rd_pipe: a RD_LAT-deep shift register of {valid, data}, with async active-low reset.
  - It is instantiated once per read port.
- The storage array and the FSM stay in the top module.

Test Plan:
- Reset and init:
  - Rst low for 3 cycles, then high: busy=1 for exactly 512 cycles, then 0.
  - A read of addr 180 then returns 99999 with valid1 after 2 cycles.
- Load and stream:
  - Write addr 180..183 with 15, 2, 11, 7 and addr 2..3 with 7, 93.
  - Back-to-back req1 at 180..183 and req2 at 2..3: dataIn1 is 15, 2, 11, 7 on consecutive cycles; dataIn2 is 7, 93; each arrives exactly 2 cycles after its request.
- Collision:
  - WR addr 200 = 13 while req1 addr 200 in the same cycle: the old value 99999 is returned.
  - The next-cycle read returns 13.
- Out-of-range:
  - req2 at addr 600 returns 99999 with valid2=1.
  - WR addr 600 = 5 followed by a read of 600 still returns 99999.
- Re-init mid-stream:
  - Issue req1 at 180, then assert mem_init one cycle later.
  - The in-flight read returns 15, busy rises, and a req1 issued during INIT produces no valid.
  - After the sweep completes, addr 180 reads 99999.
- RD_LAT=1 and RD_LAT=4 builds with alternating req1 and req2: latency is exactly 1 and exactly 4 cycles respectively.
  - With HHT_MEM_STATS_EN, rd_cnt1 and rd_cnt2 match the issued request counts.

Source files
------------

// File: rtl/hht_mem_pkg.sv
// hht_mem_pkg
//   Shared definitions for the HHT memory responder:
//     - hht_mem_state_e : sweep/serve state of the responder FSM
//     - HHT_MEM_DEFAULT : word value for unwritten / out-of-range locations
//     - RD_LAT_MIN/MAX  : legal range of the read-pipeline depth
//     - clog2_min1      : index width helper that never returns 0
//     - sat_add32       : saturating add used by the optional statistics
//                         counters (HHT_MEM_STATS_EN)
package hht_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } hht_mem_state_e;

    localparam int HHT_MEM_DEFAULT = 99999;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Adds 0..3 to a 32-bit count and sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] value,
                                              input logic [1:0]  inc);
        logic [32:0] sum;
        sum = {1'b0, value} + {31'b0, inc};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/hht_rd_pipe.sv
// hht_rd_pipe
//   Fixed-latency read pipeline for one responder port: an RD_LAT-deep shift
//   register of {valid, data}.  A beat entering on in_valid_i at edge k leaves
//   the last stage at edge k+RD_LAT-1, so a consumer sampling at edge
//   k+RD_LAT sees it.  Each data stage loads only when a valid beat moves
//   into it, so the output data holds the last delivered word between beats.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_ni      in   asynchronous active-low reset (valids 0, data RST_DATA)
//   in_valid_i  in   beat entering the pipeline this edge
//   in_data_i   in   DATA_W data of the entering beat
//   out_valid_o out  last-stage valid (one cycle per beat)
//   out_data_o  out  last-stage data (holds when out_valid_o = 0)
module hht_rd_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [DATA_W-1:0] data_q [RD_LAT];
    logic [DATA_W-1:0] data_d [RD_LAT];

    always_comb begin
        valid_d[0] = in_valid_i;
        data_d[0]  = in_valid_i ? in_data_i : data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                data_q[i] <= RST_DATA;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q[RD_LAT-1];
    assign out_data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/hht_mem_responder.sv
// hht_mem_responder
//   Memory-side responder for the HHT control block.  Port 1 serves the
//   column-index stream, port 2 the vector-value stream.  The CPU loads the
//   store through WR/wr_addr/wr_data; both read ports have a fixed,
//   fully pipelined latency of RD_LAT cycles.
//
//   After reset (and after every accepted mem_init) the FSM sits in INIT and
//   sweeps DEFAULT_DATA into words 0..DEPTH-1, one per cycle.  Reads and
//   writes are only accepted in READY.
//
//   Handshake: there is no back-pressure.  A request is accepted when reqN=1
//   is sampled at a rising edge while the FSM is READY.  Every accepted
//   request produces exactly one cycle of validN=1 with its dataInN, visible
//   to a consumer sampling at the RD_LAT-th edge after acceptance.  dataInN
//   is only meaningful while validN=1 and otherwise holds its last value.
//
// Ports
//   Clk          in   clock, rising edge
//   Rst          in   asynchronous active-low reset
//   mem_init     in   restart the clearing sweep (wins over WR)
//   WR           in   CPU write strobe
//   wr_addr      in   CPU write address (>= DEPTH is dropped)
//   wr_data      in   CPU write data
//   req1/addr1   in   port-1 read request / address
//   dataIn1      out  port-1 read data
//   valid1       out  port-1 data valid
//   req2/addr2   in   port-2 read request / address
//   dataIn2      out  port-2 read data
//   valid2       out  port-2 data valid
//   busy         out  high while the sweep runs
//   dbg_state_o  out  current FSM state
//
// Build option HHT_MEM_STATS_EN adds saturating 32-bit counters:
//   rd_cnt1, rd_cnt2  accepted reads per port
//   oor_cnt           accepted out-of-range reads, both ports
module hht_mem_responder
    import hht_mem_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter int                DEPTH        = 512,
    parameter int                RD_LAT       = 2,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = DATA_W'(HHT_MEM_DEFAULT)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 mem_init,
    input  logic                 WR,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 req1,
    input  logic [ADDR_W-1:0]    addr1,
    output logic [DATA_W-1:0]    dataIn1,
    output logic                 valid1,
    input  logic                 req2,
    input  logic [ADDR_W-1:0]    addr2,
    output logic [DATA_W-1:0]    dataIn2,
    output logic                 valid2,
    output logic                 busy,
    output hht_mem_state_e       dbg_state_o
`ifdef HHT_MEM_STATS_EN
    ,
    output logic [31:0]          rd_cnt1,
    output logic [31:0]          rd_cnt2,
    output logic [31:0]          oor_cnt
`endif
);

    localparam int                IDX_W    = clog2_min1(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // FSM: INIT sweep / READY
    // ------------------------------------------------------------------
    hht_mem_state_e   state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (mem_init) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            READY: begin
                if (mem_init) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy        = (state_q == INIT);
    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Storage: single write port shared by the sweep and the CPU.
    // The array has no reset; the sweep is what clears it.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_ready;
    logic              cpu_wr_ok;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_ready  = (state_q == READY);
    // mem_init in the same cycle cancels the CPU write.
    assign cpu_wr_ok = in_ready && WR && !mem_init && (wr_addr < DEPTH_A);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr[IDX_W-1:0];
        mem_wdata = wr_data;
        if (!in_ready) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = DEFAULT_DATA;
        end else if (cpu_wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports.  The array is read combinationally and captured by the
    // first pipeline stage on the same edge that may write the array, so a
    // colliding write is seen by reads from the following cycle onwards.
    // ------------------------------------------------------------------
    logic              acc1, acc2;
    logic              in_range1, in_range2;
    logic [DATA_W-1:0] rdata1, rdata2;

    assign acc1      = in_ready && req1;
    assign acc2      = in_ready && req2;
    assign in_range1 = (addr1 < DEPTH_A);
    assign in_range2 = (addr2 < DEPTH_A);
    assign rdata1    = in_range1 ? mem_q[addr1[IDX_W-1:0]] : DEFAULT_DATA;
    assign rdata2    = in_range2 ? mem_q[addr2[IDX_W-1:0]] : DEFAULT_DATA;

    hht_rd_pipe #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .RST_DATA (DEFAULT_DATA)
    ) u_pipe1 (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .in_valid_i  (acc1),
        .in_data_i   (rdata1),
        .out_valid_o (valid1),
        .out_data_o  (dataIn1)
    );

    hht_rd_pipe #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .RST_DATA (DEFAULT_DATA)
    ) u_pipe2 (
        .clk_i       (Clk),
        .rst_ni      (Rst),
        .in_valid_i  (acc2),
        .in_data_i   (rdata2),
        .out_valid_o (valid2),
        .out_data_o  (dataIn2)
    );

`ifdef HHT_MEM_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [31:0] rd_cnt1_q, rd_cnt1_d;
    logic [31:0] rd_cnt2_q, rd_cnt2_d;
    logic [31:0] oor_cnt_q, oor_cnt_d;
    logic [1:0]  oor_inc;

    assign oor_inc = {1'b0, acc1 && !in_range1} + {1'b0, acc2 && !in_range2};

    always_comb begin
        rd_cnt1_d = sat_add32(rd_cnt1_q, {1'b0, acc1});
        rd_cnt2_d = sat_add32(rd_cnt2_q, {1'b0, acc2});
        oor_cnt_d = sat_add32(oor_cnt_q, oor_inc);
        if (mem_init) begin
            rd_cnt1_d = '0;
            rd_cnt2_d = '0;
            oor_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_cnt1_q <= '0;
            rd_cnt2_q <= '0;
            oor_cnt_q <= '0;
        end else begin
            rd_cnt1_q <= rd_cnt1_d;
            rd_cnt2_q <= rd_cnt2_d;
            oor_cnt_q <= oor_cnt_d;
        end
    end

    assign rd_cnt1 = rd_cnt1_q;
    assign rd_cnt2 = rd_cnt2_q;
    assign oor_cnt = oor_cnt_q;
`endif

endmodule

// File: tb/tb_hht_mem_responder.sv
// tb_hht_mem_responder
//   Directed bench for hht_mem_responder.  Stimulus tasks push the
//   hand-computed response and its due cycle into per-port queues; two
//   monitors pop and compare whenever validN is seen.  RD_LAT can be
//   overridden at build time to cover other latencies.
module tb_hht_mem_responder;
    import hht_mem_pkg::*;

    parameter int RD_LAT = 2;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 512;
    localparam int DEF    = 99999;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              mem_init = 1'b0;
    logic              WR       = 1'b0;
    logic [ADDR_W-1:0] wr_addr  = '0;
    logic [DATA_W-1:0] wr_data  = '0;
    logic              req1     = 1'b0;
    logic [ADDR_W-1:0] addr1    = '0;
    logic              req2     = 1'b0;
    logic [ADDR_W-1:0] addr2    = '0;
    logic [DATA_W-1:0] dataIn1, dataIn2;
    logic              valid1, valid2, busy;
    hht_mem_state_e    dbg_state;
`ifdef HHT_MEM_STATS_EN
    logic [31:0]       rd_cnt1, rd_cnt2, oor_cnt;
`endif

    hht_mem_responder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .mem_init    (mem_init),
        .WR          (WR),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .req1        (req1),
        .addr1       (addr1),
        .dataIn1     (dataIn1),
        .valid1      (valid1),
        .req2        (req2),
        .addr2       (addr2),
        .dataIn2     (dataIn2),
        .valid2      (valid2),
        .busy        (busy),
        .dbg_state_o (dbg_state)
`ifdef HHT_MEM_STATS_EN
        ,
        .rd_cnt1     (rd_cnt1),
        .rd_cnt2     (rd_cnt2),
        .oor_cnt     (oor_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q1[$];
    logic [DATA_W-1:0] exp_q2[$];
    int                due_q1[$];
    int                due_q2[$];
    int                n_vec = 0;
    int                n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge Clk) begin : mon1
        logic [DATA_W-1:0] e;
        int                d;
        if (valid1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("p1_unexpected_valid", 1, 0);
            end else begin
                e = exp_q1.pop_front();
                d = due_q1.pop_front();
                check("p1_data", longint'(dataIn1), longint'(e));
                check("p1_latency", cyc, d);
            end
        end
    end

    always @(negedge Clk) begin : mon2
        logic [DATA_W-1:0] e;
        int                d;
        if (valid2 === 1'b1) begin
            if (exp_q2.size() == 0) begin
                check("p2_unexpected_valid", 1, 0);
            end else begin
                e = exp_q2.pop_front();
                d = due_q2.pop_front();
                check("p2_data", longint'(dataIn2), longint'(e));
                check("p2_latency", cyc, d);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle of stimulus, applied at a falling edge.  expect_resp says
    // whether the bench expects the DUT to accept the requests (READY).
    task automatic step(input bit r1, input int a1, input int e1,
                        input bit r2, input int a2, input int e2,
                        input bit wr, input int wa, input int wd,
                        input bit mi, input bit expect_resp);
        req1     = r1;
        addr1    = a1;
        req2     = r2;
        addr2    = a2;
        WR       = wr;
        wr_addr  = wa;
        wr_data  = wd;
        mem_init = mi;
        if (expect_resp && r1) begin
            exp_q1.push_back(e1);
            due_q1.push_back(cyc + RD_LAT);
        end
        if (expect_resp && r2) begin
            exp_q2.push_back(e2);
            due_q2.push_back(cyc + RD_LAT);
        end
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_word(input int wa, input int wd);
        step(0, 0, 0, 0, 0, 0, 1, wa, wd, 0, 0);
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            cycles++;
            @(negedge Clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;

        // Reset held for 3 cycles
        #1 Rst = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_valid1", valid1, 0);
        check("rst_valid2", valid2, 0);
        check("rst_dataIn1", dataIn1, DEF);
        check("rst_dataIn2", dataIn2, DEF);
        check("rst_busy", busy, 1);
`ifdef HHT_MEM_STATS_EN
        check("rst_rd_cnt1", rd_cnt1, 0);
`endif
        Rst = 1'b1;
        wait_ready(busy_cycles);
        check("init_busy_cycles", busy_cycles, DEPTH);

        // Swept word reads back as the default
        step(1, 180, DEF, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(RD_LAT + 1);

        // Load
        wr_word(180, 15);
        wr_word(181, 2);
        wr_word(182, 11);
        wr_word(183, 7);
        wr_word(2, 7);
        wr_word(3, 93);

        // Back-to-back streams on both ports
        step(1, 180, 15, 1, 2, 7, 0, 0, 0, 0, 1);
        step(1, 181, 2, 1, 3, 93, 0, 0, 0, 0, 1);
        step(1, 182, 11, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 183, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(RD_LAT + 3);
        check("hold_dataIn1", dataIn1, 7);
        check("hold_dataIn2", dataIn2, 93);

        // Read/write collision, then both ports on the same address
        step(1, 200, DEF, 0, 0, 0, 1, 200, 13, 0, 1);
        step(1, 200, 13, 1, 200, 13, 0, 0, 0, 0, 1);
        idle(RD_LAT + 1);

        // Out of range: read, dropped write, simultaneous reads
        step(0, 0, 0, 1, 600, DEF, 0, 0, 0, 0, 1);
        wr_word(600, 5);
        step(1, 600, DEF, 1, 600, DEF, 0, 0, 0, 0, 1);
        idle(RD_LAT + 1);
`ifdef HHT_MEM_STATS_EN
        check("stats_rd_cnt1", rd_cnt1, 8);
        check("stats_rd_cnt2", rd_cnt2, 5);
        check("stats_oor_cnt", oor_cnt, 3);
`endif

        // Re-init with a read in flight
        step(1, 180, 15, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("reinit_busy", busy, 1);
        step(1, 180, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        step(1, 181, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        idle(10);
        wr_word(0, 55);
        idle(2);
        wait_ready(busy_cycles);
        check("reinit_done", busy, 0);
`ifdef HHT_MEM_STATS_EN
        check("stats_cleared_by_init", rd_cnt1, 0);
`endif
        step(1, 180, DEF, 1, 0, DEF, 0, 0, 0, 0, 1);
        idle(RD_LAT + 1);

        // Reset during a read: the in-flight beat must vanish
        wr_word(10, 77);
        step(1, 10, 77, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(RD_LAT + 1);
        check("pre_reset_dataIn1", dataIn1, 77);
        req1  = 1'b1;
        addr1 = 10;
        @(posedge Clk);
        #1;
        Rst  = 1'b0;
        req1 = 1'b0;
        @(negedge Clk);
        check("midrst_valid1", valid1, 0);
        check("midrst_dataIn1", dataIn1, DEF);
        check("midrst_busy", busy, 1);
`ifdef HHT_MEM_STATS_EN
        check("midrst_rd_cnt1", rd_cnt1, 0);
`endif
        Rst = 1'b1;
        idle(RD_LAT + 2);
        wait_ready(busy_cycles);
        check("midrst_reinit_cycles", busy_cycles, DEPTH - RD_LAT - 2);
        step(1, 10, DEF, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(RD_LAT + 2);

        // Everything pushed must have been delivered
        for (int i = 0; i < 20 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++) begin
            @(negedge Clk);
        end
        check("p1_queue_drained", exp_q1.size(), 0);
        check("p2_queue_drained", exp_q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
